// File: rtl/dmem_arbiter_if.sv
// Bundle of the core (c_*), debug (d_*) and memory (m_*) buses seen by dmem_arbiter.
// slave is the arbiter's view; master is the surrounding core/debugger/memory view.
interface dmem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic            c_req;
    logic            c_we;
    logic [AW-1:0]   c_addr;
    logic [DW-1:0]   c_wdata;
    logic [DW/8-1:0] c_wmask;
    logic            c_gnt;
    logic            c_stall;
    logic            c_rvalid;
    logic [DW-1:0]   c_rdata;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wmask;
    logic            d_lock;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            m_en;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wmask;
    logic [DW-1:0]   m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_wmask,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wmask, d_lock,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata, m_wmask,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_wmask,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wmask, d_lock,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, m_wmask,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the core (C) and a
// debug/loader port (D), with a debug lock for exclusive bursts and read-data routing.
module dmem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {OPEN, LOCKED} mode_e;

    mode_e mode_q, mode_d;
    logic  last_q, last_d;
    logic  rpend_q, rpend_d;
    logic  rsel_q, rsel_d;

    logic            gnt_c, gnt_d;
    logic            we_mux;
    logic [AW-1:0]   addr_mux;
    logic [DW-1:0]   wdata_mux;
    logic [DW/8-1:0] wmask_mux;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= OPEN;
            last_q  <= 1'b1;
            rpend_q <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            last_q  <= last_d;
            rpend_q <= rpend_d;
            rsel_q  <= rsel_d;
        end
    end

    always_comb begin
        gnt_c  = 1'b0;
        gnt_d  = 1'b0;
        mode_d = mode_q;
        last_d = last_q;

        // Grants are gated by reset so nothing reaches memory while rst is low.
        if (rst) begin
            if (mode_q == LOCKED && bus.d_lock) begin
                gnt_d = bus.d_req;
            end else if (bus.c_req && bus.d_req) begin
                // Releasing a lock hands the contested cycle to the core.
                if (mode_q == LOCKED || last_q) gnt_c = 1'b1;
                else                            gnt_d = 1'b1;
            end else begin
                gnt_c = bus.c_req;
                gnt_d = bus.d_req;
            end
        end

        if (gnt_c)      last_d = 1'b0;
        else if (gnt_d) last_d = 1'b1;

        unique case (mode_q)
            OPEN:    if (gnt_d && bus.d_lock) mode_d = LOCKED;
            LOCKED:  if (!bus.d_lock)         mode_d = OPEN;
            default: mode_d = OPEN;
        endcase
    end

    always_comb begin
        we_mux    = 1'b0;
        addr_mux  = bus.c_addr;
        wdata_mux = bus.c_wdata;
        wmask_mux = '0;
        if (gnt_c) begin
            we_mux    = bus.c_we;
            wmask_mux = bus.c_wmask;
        end else if (gnt_d) begin
            we_mux    = bus.d_we;
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
            wmask_mux = bus.d_wmask;
        end
    end

    always_comb begin
        rpend_d = (gnt_c | gnt_d) & ~we_mux;
        rsel_d  = gnt_d;
    end

    assign bus.m_en     = gnt_c | gnt_d;
    assign bus.m_we     = we_mux;
    assign bus.m_addr   = addr_mux;
    assign bus.m_wdata  = wdata_mux;
    assign bus.m_wmask  = wmask_mux;

    assign bus.c_gnt    = gnt_c;
    assign bus.d_gnt    = gnt_d;
    assign bus.c_stall  = rst & bus.c_req & ~gnt_c;

    assign bus.c_rvalid = rpend_q & ~rsel_q;
    assign bus.d_rvalid = rpend_q & rsel_q;
    assign bus.c_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic, checked every cycle
// against a transaction-level model (winner choice, lock mode, expected-response queue, memory image).
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory attached to the arbiter's m_* side, one-cycle read latency.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) begin
                for (int b = 0; b < MW; b++)
                    if (bus.m_wmask[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            end else begin
                bus.m_rdata <= mem[bus.m_addr];
            end
        end
    end

    // Reference model state
    typedef struct {
        bit            to_d;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] ref_mem [0:DEPTH-1];
    rd_t           rdq[$];
    bit            mdl_locked;
    bit            mdl_last_d;
    bit            w_c, w_d;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic set_c(input bit req, input bit we, input int addr, input logic [DW-1:0] wd,
                         input logic [MW-1:0] wm);
        bus.c_req = req; bus.c_we = we; bus.c_addr = AW'(addr);
        bus.c_wdata = wd; bus.c_wmask = wm;
    endtask

    task automatic set_d(input bit req, input bit we, input int addr, input logic [DW-1:0] wd,
                         input logic [MW-1:0] wm, input bit lock);
        bus.d_req = req; bus.d_we = we; bus.d_addr = AW'(addr);
        bus.d_wdata = wd; bus.d_wmask = wm; bus.d_lock = lock;
    endtask

    task automatic idle();
        set_c(0, 0, 0, '0, '0);
        set_d(0, 0, 0, '0, '0, 0);
    endtask

    // Observe mid-cycle: decide who should win and what the memory/response side must show.
    task automatic check_phase();
        bit            prefer_c, exp_we, exp_cv, exp_dv;
        logic [MW-1:0] exp_mask;
        rd_t           e;
        @(negedge clk);
        w_c = 0;
        w_d = 0;
        if (mdl_locked && bus.d_lock) begin
            w_d = bus.d_req;
        end else begin
            prefer_c = mdl_locked || mdl_last_d;
            if (bus.c_req && (prefer_c || !bus.d_req)) w_c = 1;
            else if (bus.d_req)                        w_d = 1;
        end
        exp_we   = w_c ? bus.c_we    : (w_d ? bus.d_we    : 1'b0);
        exp_mask = w_c ? bus.c_wmask : (w_d ? bus.d_wmask : '0);
        check_val("c_gnt",   bus.c_gnt,   w_c);
        check_val("d_gnt",   bus.d_gnt,   w_d);
        check_val("c_stall", bus.c_stall, bus.c_req && !w_c);
        check_val("m_en",    bus.m_en,    w_c || w_d);
        check_val("m_we",    bus.m_we,    exp_we);
        check_val("m_wmask", bus.m_wmask, exp_mask);
        if (w_c || w_d) check_val("m_addr", bus.m_addr, w_c ? bus.c_addr : bus.d_addr);
        if (exp_we)     check_val("m_wdata", bus.m_wdata, w_c ? bus.c_wdata : bus.d_wdata);
        exp_cv = 0;
        exp_dv = 0;
        if (rdq.size() > 0) begin
            e = rdq.pop_front();
            if (e.to_d) exp_dv = 1; else exp_cv = 1;
            check_val(e.to_d ? "d_rdata" : "c_rdata", e.to_d ? bus.d_rdata : bus.c_rdata, e.data);
        end
        check_val("c_rvalid", bus.c_rvalid, exp_cv);
        check_val("d_rvalid", bus.d_rvalid, exp_dv);
    endtask

    // Advance the model across the clock edge.
    task automatic commit_phase();
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [MW-1:0] wm;
        rd_t           e;
        @(posedge clk);
        if (w_c || w_d) begin
            we = w_c ? bus.c_we    : bus.d_we;
            a  = w_c ? bus.c_addr  : bus.d_addr;
            wd = w_c ? bus.c_wdata : bus.d_wdata;
            wm = w_c ? bus.c_wmask : bus.d_wmask;
            if (we) begin
                for (int b = 0; b < MW; b++) if (wm[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.to_d = w_d;
                e.data = ref_mem[a];
                rdq.push_back(e);
            end
            mdl_last_d = w_d;
        end
        if (!mdl_locked && w_d && bus.d_lock) mdl_locked = 1;
        else if (mdl_locked && !bus.d_lock)   mdl_locked = 0;
        #1;
    endtask

    task automatic step();
        check_phase();
        commit_phase();
    endtask

    task automatic apply_reset();
        #2 rst = 1'b0;
        set_c(1, 0, 1, '0, '0);
        set_d(1, 0, 2, '0, '0, 1);
        #1;
        check_val("rst_c_gnt",    bus.c_gnt,    1'b0);
        check_val("rst_d_gnt",    bus.d_gnt,    1'b0);
        check_val("rst_c_stall",  bus.c_stall,  1'b0);
        check_val("rst_m_en",     bus.m_en,     1'b0);
        check_val("rst_m_we",     bus.m_we,     1'b0);
        check_val("rst_m_wmask",  bus.m_wmask,  '0);
        check_val("rst_c_rvalid", bus.c_rvalid, 1'b0);
        check_val("rst_d_rvalid", bus.d_rvalid, 1'b0);
        mdl_locked = 0;
        mdl_last_d = 1;
        rdq.delete();
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit c_hold, d_hold;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        mem[16] = 32'hA1B2C3D4;
        ref_mem[16] = 32'hA1B2C3D4;
        bus.m_rdata = '0;
        idle();
        apply_reset();

        // Core-only read of 0x005
        set_c(1, 0, 5, '0, '0);
        step();
        idle();
        step();

        // Continuous contention from reset: C,D,C,D,C,D
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            set_c(1, 0, 32 + k, '0, '0);
            set_d(1, 0, 64 + k, '0, '0, 0);
            step();
        end
        idle();
        step();

        // Partial-mask debug write, then core read of the same word
        set_d(1, 1, 16, 32'h12345678, 4'b0011, 0);
        step();
        idle();
        set_c(1, 0, 16, '0, '0);
        step();
        idle();
        step();

        // Locked debug burst of 4 writes with the core waiting, then lock release
        for (int k = 0; k < 4; k++) begin
            set_c(1, 0, 7, '0, '0);
            set_d(1, 1, 100 + k, $urandom, 4'b1111, 1);
            step();
        end
        set_c(1, 0, 7, '0, '0);
        set_d(1, 0, 8, '0, '0, 0);
        step();
        idle();
        step();

        // Core read granted, then reset before the response edge
        set_c(1, 0, 5, '0, '0);
        check_phase();
        apply_reset();
        set_c(1, 0, 9, '0, '0);
        set_d(1, 0, 10, '0, '0, 0);
        step();
        idle();
        step();

        // Interleaved C read, D read, C write
        set_c(1, 0, 20, '0, '0);
        step();
        idle();
        set_d(1, 0, 21, '0, '0, 0);
        step();
        idle();
        set_c(1, 1, 22, 32'hCAFEF00D, 4'b1111);
        step();
        idle();
        step();
        step();

        // Randomized traffic with hold-until-granted requesters
        c_hold = 0;
        d_hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (!c_hold)
                set_c($urandom_range(9) < 6, $urandom_range(1), $urandom_range(15), $urandom,
                      MW'($urandom));
            if (!d_hold)
                set_d($urandom_range(9) < 5, $urandom_range(1), $urandom_range(15), $urandom,
                      MW'($urandom), bus.d_lock);
            if ($urandom_range(7) == 0) bus.d_lock = ~bus.d_lock;
            if ($urandom_range(249) == 0) begin
                check_phase();
                apply_reset();
                c_hold = 0;
                d_hold = 0;
            end else begin
                step();
                c_hold = bus.c_req && !w_c;
                d_hold = bus.d_req && !w_d;
            end
        end
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed in front of the processor's single-port data memory. It shares the memory between the core's load/store port (port C) and a debug/loader port (port D), which is used to preload or inspect data memory while the core runs. It applies round-robin arbitration with an optional debug lock for exclusive bursts. It also routes the one-cycle-latency read data back to the requester that issued the read.

## Interface
- AW, 10, word-address width
- DW, 32, data width; byte-mask width is DW/8
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- c_req  in  1  core requests an access this cycle
- c_we  in  1  core write (1) / read (0)
- c_addr  in  AW  core word address
- c_wdata  in  DW  core write data
- c_wmask  in  DW/8  core byte enables
- c_gnt  out  1  core access accepted this cycle
- c_stall  out  1  c_req & ~c_gnt; freezes the core's PC and pipeline
- c_rvalid  out  1  core read data valid
- c_rdata  out  DW  core read data
- d_req, d_we, d_addr, d_wdata, d_wmask  in  1/1/AW/DW/DW/8  debug-port equivalents of the core inputs
- d_lock  in  1  debug requests exclusive ownership
- d_gnt  out  1  debug access accepted this cycle
- d_rvalid  out  1  debug read data valid
- d_rdata  out  DW  debug read data
- m_en, m_we  out  1  memory enable and write strobe
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_wmask  out  DW/8  memory byte enables
- m_rdata  in  DW  memory read data, valid one cycle after a read with m_en=1

## Operation
- State: mode ∈ {OPEN, LOCKED}; last (0=C, 1=D) records the most recent grant; rpend flag; rsel (0=C, 1=D).
- Grant is combinational from requests and state. At most one grant per cycle. Every cycle may grant, so accesses are fully pipelined.
- OPEN:
  - Only one requester → grant it.
  - Both request → grant the one not equal to last.
- LOCKED:
  - Only D can be granted; c_gnt=0 regardless of c_req.
  - If d_lock=0 in a LOCKED cycle, arbitration that cycle follows OPEN rules with C preferred.
- Mode transitions, evaluated at the clock edge:
  - OPEN→LOCKED when d_gnt & d_lock.
  - LOCKED→OPEN when ~d_lock.
  - Otherwise hold.
- last is updated to the granted port on any grant; it holds when there is no grant.
- Memory mux:
  - m_en = c_gnt | d_gnt.
  - m_we, m_addr, m_wdata, m_wmask are taken from the granted port.
  - m_we=0 and m_wmask=0 when there is no grant.
- Read tracking:
  - At the edge: rpend ← m_en & ~m_we; rsel ← d_gnt.
  - c_rvalid = rpend & ~rsel; d_rvalid = rpend & rsel.
  - c_rdata = d_rdata = m_rdata. Consumers use the data only when their rvalid is high.
- Writes produce no response; a write is complete on its grant edge.
- A write with all mask bits zero is still granted and still sets m_en.

## Timing
- Reset (rst=0), asynchronous: mode=OPEN, last=1 (so C wins the first tie), rpend=0, rsel=0.
  - While in reset, all grants, m_en, m_we, m_wmask, c_rvalid, d_rvalid are 0, and c_stall=0 is forced.
- Grant latency is 0 cycles: req and gnt occur in the same cycle, with no registered stage.
- Read latency: rvalid appears exactly 1 cycle after the granted read cycle.
- Back-to-back reads yield back-to-back rvalids in grant order.
- A requester must hold its request and payload stable until it sees gnt. The arbiter never retracts a grant within a cycle.
- Under continuous contention in OPEN mode, grants alternate C, D, C, D; neither port waits more than 1 cycle.
- Reset asserted mid-read: the pending rvalid is dropped and never reaches the requester. The first post-reset cycle arbitrates from the reset state.
- Simultaneous events at one edge:
  - d_gnt & d_lock entering LOCKED with rpend set: rvalid is still delivered normally.
  - LOCKED with ~d_lock and both requesting: C is granted that cycle.

## Test plan
- Core-only read, addr 0x005, memory word 0xDEADBEEF → c_gnt=1 same cycle; next cycle c_rvalid=1, c_rdata=0xDEADBEEF, d_rvalid=0.
- Both ports request reads continuously for 6 cycles after reset → grant order C,D,C,D,C,D; c_stall high on cycles 2, 4, 6; each rvalid lands on the correct port.
- D write 0x12345678, mask 4'b0011, to 0x010, then C read of 0x010 → memory sees m_wmask=0011; the C read returns 0x????5678 with the upper bytes unchanged.
- D holds d_lock=1 with 4 consecutive writes while C requests → c_gnt=0 and c_stall=1 for 4 cycles. d_lock drops with C still requesting → C granted in that cycle.
- C read granted, then rst pulled low before the next edge → no c_rvalid appears. After release, the first tie goes to C.
- Interleaved C read / D read / C write on consecutive cycles → rvalid pattern: C at cycle+1, D at cycle+2, nothing for the write; m_we=1 only in the write cycle.
